// File: rtl/prefix_arith_pkg.sv
// rtl/prefix_arith_pkg.sv - shared word width, subtractor states, and prefix generate/propagate helpers
package prefix_arith_pkg;

    localparam int WORD_W = 6;

    typedef enum logic {
        FIRST,
        CHAIN
    } sub_state_t;

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    // Combines a higher span (hi) with the adjacent lower span (lo).
    function automatic gp_t dot(input gp_t hi, input gp_t lo);
        gp_t r;
        r.g = hi.g | (hi.p & lo.g);
        r.p = hi.p & lo.p;
        return r;
    endfunction

endpackage

// File: rtl/prefix_sub_serial_if.sv
// rtl/prefix_sub_serial_if.sv - word-pair input stream and difference output stream (out_zero with PREFIX_SUB_ZERO_FLAG_EN)
interface prefix_sub_serial_if;
    import prefix_arith_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_x;
    logic [WORD_W-1:0] in_y;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_d;
    logic              out_last;
    logic              out_borrow;
    logic              out_ov;
`ifdef PREFIX_SUB_ZERO_FLAG_EN
    logic              out_zero;

    modport master (
        output in_valid, in_x, in_y, in_last, out_ready,
        input  in_ready, out_valid, out_d, out_last, out_borrow, out_ov, out_zero
    );
    modport slave (
        input  in_valid, in_x, in_y, in_last, out_ready,
        output in_ready, out_valid, out_d, out_last, out_borrow, out_ov, out_zero
    );
`else
    modport master (
        output in_valid, in_x, in_y, in_last, out_ready,
        input  in_ready, out_valid, out_d, out_last, out_borrow, out_ov
    );
    modport slave (
        input  in_valid, in_x, in_y, in_last, out_ready,
        output in_ready, out_valid, out_d, out_last, out_borrow, out_ov
    );
`endif

endinterface

// File: rtl/prefix_sub6.sv
// rtl/prefix_sub6.sv - combinational 6-bit x + ~y + cin using a 3-level Ladner-Fischer carry network
module prefix_sub6
    import prefix_arith_pkg::*;
(
    input  logic [WORD_W-1:0] x,
    input  logic [WORD_W-1:0] y,
    input  logic              cin,
    output logic [WORD_W-1:0] d,
    output logic              c5,
    output logic              cout
);

    logic [WORD_W-1:0] g;
    logic [WORD_W-1:0] p;
    logic [WORD_W:0]   c;
    gp_t               bit_gp [WORD_W];
    gp_t               l1_10, l1_32, l1_54;
    gp_t               l2_20, l2_30;
    gp_t               l3_40, l3_50;
    logic              unused_grp_p;

    assign g = x & ~y;
    assign p = ~(x ^ y);

    // Carry-in is folded into bit 0's generate so every prefix span starts at cin.
    always_comb begin
        for (int i = 0; i < WORD_W; i++) begin
            bit_gp[i].g = g[i];
            bit_gp[i].p = p[i];
        end
        bit_gp[0].g = g[0] | (p[0] & cin);
    end

    assign l1_10 = dot(bit_gp[1], bit_gp[0]);
    assign l1_32 = dot(bit_gp[3], bit_gp[2]);
    assign l1_54 = dot(bit_gp[5], bit_gp[4]);
    assign l2_20 = dot(bit_gp[2], l1_10);
    assign l2_30 = dot(l1_32, l1_10);
    assign l3_40 = dot(bit_gp[4], l2_30);
    assign l3_50 = dot(l1_54, l2_30);

    assign c    = {l3_50.g, l3_40.g, l2_30.g, l2_20.g, l1_10.g, bit_gp[0].g, cin};
    assign d    = p ^ c[WORD_W-1:0];
    assign c5   = c[WORD_W-1];
    assign cout = c[WORD_W];

    assign unused_grp_p = l2_20.p ^ l3_40.p ^ l3_50.p;

endmodule

// File: rtl/prefix_sub_serial.sv
// rtl/prefix_sub_serial.sv - serial multi-word X - Y with chained borrow, borrow/overflow flags, optional PREFIX_SUB_ZERO_FLAG_EN
module prefix_sub_serial
    import prefix_arith_pkg::*;
#(
    parameter int WORDS = 4
) (
    input logic               clk,
    input logic               rst_n,
    prefix_sub_serial_if.slave bus
);

    sub_state_t        state;
    logic              carry;
    logic [3:0]        word_idx;
    logic              accept;
    logic              final_word;
    logic              cin;
    logic [WORD_W-1:0] d;
    logic              c5;
    logic              cout;

    assign bus.in_ready = !bus.out_valid || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;
    assign final_word   = bus.in_last || (word_idx == 4'(WORDS - 1));
    assign cin          = (state == FIRST) ? 1'b1 : carry;

    prefix_sub6 u_sub6 (
        .x    (bus.in_x),
        .y    (bus.in_y),
        .cin  (cin),
        .d    (d),
        .c5   (c5),
        .cout (cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= FIRST;
            carry          <= 1'b0;
            word_idx       <= 4'd0;
            bus.out_valid  <= 1'b0;
            bus.out_d      <= '0;
            bus.out_last   <= 1'b0;
            bus.out_borrow <= 1'b0;
            bus.out_ov     <= 1'b0;
        end else if (accept) begin
            bus.out_valid  <= 1'b1;
            bus.out_d      <= d;
            bus.out_last   <= final_word;
            bus.out_borrow <= final_word & ~cout;
            bus.out_ov     <= final_word & (c5 ^ cout);
            carry          <= cout;
            state          <= final_word ? FIRST : CHAIN;
            word_idx       <= final_word ? 4'd0 : word_idx + 4'd1;
        end else if (bus.out_ready) begin
            bus.out_valid  <= 1'b0;
        end
    end

`ifdef PREFIX_SUB_ZERO_FLAG_EN
    logic sticky_nz;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_nz    <= 1'b0;
            bus.out_zero <= 1'b0;
        end else if (accept) begin
            sticky_nz    <= final_word ? 1'b0 : (sticky_nz | (|d));
            bus.out_zero <= final_word & ~(sticky_nz | (|d));
        end
    end
`endif

endmodule

// File: tb/tb_prefix_sub_serial.sv
// tb/tb_prefix_sub_serial.sv - randomized and directed checks of prefix_sub_serial against a whole-operand arithmetic model
module tb_prefix_sub_serial;

    localparam int WORDS = 4;

    typedef struct {
        logic [5:0] d;
        logic       last;
        logic       borrow;
        logic       ov;
        logic       zero;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    prefix_sub_serial_if bus ();

    prefix_sub_serial #(.WORDS(WORDS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int         errors = 0;
    int         checks = 0;
    exp_t       exp_q[$];
    logic [127:0] mx = '0;
    logic [127:0] my = '0;
    int         mk = 0;
    bit         last_acc = 0;
    bit         stalled = 0;
    logic [5:0] held_d = '0;
    bit         rnd_ready = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected word computed from the full operands seen so far.
    task automatic model_accept(input logic [5:0] x, input logic [5:0] y, input logic l);
        exp_t               e;
        logic [127:0]        one, mask, dd;
        logic signed [127:0] sx, sy, sd, lim;
        int                  n;
        bit                  fin;
        fin  = l || (mk == WORDS - 1);
        mx   = mx | (128'(x) << (6 * mk));
        my   = my | (128'(y) << (6 * mk));
        n    = 6 * (mk + 1);
        one  = 128'd1;
        mask = (one << n) - one;
        dd   = (mx - my) & mask;
        e.d      = 6'((dd >> (6 * mk)) & 128'h3f);
        e.last   = fin;
        e.borrow = 1'b0;
        e.ov     = 1'b0;
        e.zero   = 1'b0;
        if (fin) begin
            e.borrow = (mx < my);
            sx  = mx[n-1] ? $signed(mx - (one << n)) : $signed(mx);
            sy  = my[n-1] ? $signed(my - (one << n)) : $signed(my);
            sd  = sx - sy;
            lim = $signed(one << (n - 1));
            e.ov   = (sd >= lim) || (sd < -lim);
            e.zero = (dd == 128'd0);
            mx = '0;
            my = '0;
            mk = 0;
        end else begin
            mk++;
        end
        exp_q.push_back(e);
    endtask

    task automatic model_reset();
        mx = '0;
        my = '0;
        mk = 0;
        exp_q.delete();
        stalled = 0;
    endtask

    task automatic step();
        exp_t e;
        #1;
        if (stalled) begin
            check("stall_hold_d", 32'(bus.out_d), 32'(held_d));
            check("stall_hold_valid", 32'(bus.out_valid), 32'd1);
        end
        if (bus.out_valid && !bus.out_ready)
            check("stall_in_ready", 32'(bus.in_ready), 32'd0);
        if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("out_d", 32'(bus.out_d), 32'(e.d));
                check("out_last", 32'(bus.out_last), 32'(e.last));
                check("out_borrow", 32'(bus.out_borrow), 32'(e.borrow));
                check("out_ov", 32'(bus.out_ov), 32'(e.ov));
`ifdef PREFIX_SUB_ZERO_FLAG_EN
                if (e.last) check("out_zero", 32'(bus.out_zero), 32'(e.zero));
`endif
            end
        end
        last_acc = bus.in_valid && bus.in_ready;
        if (last_acc) model_accept(bus.in_x, bus.in_y, bus.in_last);
        stalled = bus.out_valid && !bus.out_ready;
        held_d  = bus.out_d;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [5:0] x, input logic [5:0] y, input logic l);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_x     = x;
        bus.in_y     = y;
        bus.in_last  = l;
        do begin
            if (rnd_ready) bus.out_ready = ($urandom_range(0, 9) < 7);
            step();
            n++;
        end while (!last_acc && n < 50);
        if (!last_acc) check("send_timeout", 32'd0, 32'd1);
        bus.in_valid = 1'b0;
    endtask

    task automatic check_out(input string tag, input logic [5:0] d, input logic last,
                             input logic borrow, input logic ov);
        check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, "_d"}, 32'(bus.out_d), 32'(d));
        check({tag, "_last"}, 32'(bus.out_last), 32'(last));
        check({tag, "_borrow"}, 32'(bus.out_borrow), 32'(borrow));
        check({tag, "_ov"}, 32'(bus.out_ov), 32'(ov));
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_x      = '0;
        bus.in_y      = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_d", 32'(bus.out_d), 32'd0);
        check("rst_last", 32'(bus.out_last), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);

        send(6'h05, 6'h03, 1'b1);
        check_out("single", 6'h02, 1'b1, 1'b0, 1'b0);
        send(6'h20, 6'h01, 1'b1);
        check_out("sovf", 6'h1f, 1'b1, 1'b0, 1'b1);
        send(6'h00, 6'h01, 1'b1);
        check_out("sborrow", 6'h3f, 1'b1, 1'b1, 1'b0);

        send(6'h00, 6'h01, 1'b0);
        check_out("chain_w0", 6'h3f, 1'b0, 1'b0, 1'b0);
        send(6'h01, 6'h00, 1'b1);
        check_out("chain_w1", 6'h00, 1'b1, 1'b0, 1'b0);
`ifdef PREFIX_SUB_ZERO_FLAG_EN
        check("chain_zero", 32'(bus.out_zero), 32'd0);
`endif

        repeat (4) send(6'h3f, 6'h3f, 1'b0);
        check_out("forced", 6'h00, 1'b1, 1'b0, 1'b0);
`ifdef PREFIX_SUB_ZERO_FLAG_EN
        check("forced_zero", 32'(bus.out_zero), 32'd1);
`endif
        repeat (3) send(6'h00, 6'h00, 1'b0);
        send(6'h00, 6'h01, 1'b0);
        check_out("forced_b", 6'h3f, 1'b1, 1'b1, 1'b0);
        send(6'h04, 6'h01, 1'b1);
        check_out("after_forced", 6'h03, 1'b1, 1'b0, 1'b0);

        send(6'h10, 6'h20, 1'b0);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_x      = 6'h05;
        bus.in_y      = 6'h09;
        bus.in_last   = 1'b0;
        repeat (3) step();
        bus.out_ready = 1'b1;
        send(6'h05, 6'h09, 1'b0);
        send(6'h07, 6'h02, 1'b1);

        send(6'h01, 6'h02, 1'b0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_d", 32'(bus.out_d), 32'd0);
        check("mid_rst_borrow", 32'(bus.out_borrow), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        send(6'h04, 6'h01, 1'b1);
        check_out("post_rst", 6'h03, 1'b1, 1'b0, 1'b0);

        rnd_ready = 1;
        for (int t = 0; t < 300; t++) begin
            int len;
            len = $urandom_range(1, 6);
            for (int w = 0; w < len; w++) begin
                if ($urandom_range(0, 4) == 0) begin
                    bus.out_ready = ($urandom_range(0, 9) < 7);
                    step();
                end
                send(6'($urandom), 6'($urandom), (w == len - 1));
            end
        end
        rnd_ready = 0;
        bus.out_ready = 1'b1;
        repeat (4) step();
        check("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/prefix_sub_serial.md
# prefix_sub_serial

- Sequential multi-word subtractor computing D = X − Y over operands of up to WORDS 6-bit words.
- Words arrive least-significant first over a valid/ready stream.
- Each word is processed by the team's 6-bit parallel-prefix carry network, operating in subtract mode (X + ~Y + cin).
- The borrow is chained between words, and each transaction reports a final unsigned-borrow flag and a signed-overflow flag.
- It is the inverse-operation companion of the combinational 6-bit prefix adder and sits in the same arithmetic datapath.

## Interface
- WORDS, default 4: maximum words per operand (2..16); a transaction is force-terminated at this count.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  word pair present.
- in_ready  out  1  block accepts word this cycle.
- in_x  in  6  minuend word.
- in_y  in  6  subtrahend word.
- in_last  in  1  final word of operand.
- out_valid  out  1  result word present.
- out_ready  in  1  consumer accepts result.
- out_d  out  6  difference word.
- out_last  out  1  final word of result.
- out_borrow  out  1  unsigned X < Y; meaningful only with out_last.
- out_ov  out  1  signed two's-complement overflow; meaningful only with out_last.
- out_zero  out  1  whole difference is zero (present only with PREFIX_SUB_ZERO_FLAG_EN); meaningful only with out_last.

## Operation
- Handshake:
  - An input word is accepted when in_valid && in_ready.
  - A result word is consumed when out_valid && out_ready.
  - in_ready = !out_valid || out_ready (one-entry output register, full throughput).
- States:
  - FIRST: the next accepted word uses cin = 1.
  - CHAIN: the next accepted word uses cin = the registered carry-out of the previous word.
- State transitions:
  - FIRST→CHAIN: on accepting a non-final word.
  - Any state→FIRST: on accepting the final word.
- Per word:
  - {cout, d} = in_x + ~in_y + cin, computed with 3-level Ladner-Fischer generate/propagate.
  - c5, the carry into bit 5, is also extracted.
- Final word: the word where in_last = 1, or where word_idx == WORDS−1 (forced last; any in_last value is ignored).
- word_idx:
  - 4-bit counter, increments per accepted word.
  - Clears on the final word.
- Results registered with the final word:
  - out_borrow = !cout.
  - out_ov = c5 ^ cout.
  - out_last = 1.
- On non-final words, out_borrow, out_ov and out_zero are driven 0.
- Single-word transaction (in_last on the first word): plain 6-bit subtract with cin = 1.
- Output stall: out_* hold stable while out_valid && !out_ready. No input is accepted, and the chain state is frozen.

## Timing
- Latency: result word valid one cycle after acceptance.
- Throughput: one word per cycle with out_ready held high.
- Reset (asynchronous assert, synchronous deassert) drives:
  - out_valid = 0, out_d = 0, out_last = 0, out_borrow = 0, out_ov = 0, out_zero = 0.
  - state = FIRST, word_idx = 0, carry register = 0.
  - in_ready = 1 in the first cycle after reset release.
- Reset mid-transaction discards partial results. The next word accepted is treated as first (cin = 1).
- Simultaneous consume and accept: the output register loads the new word in the same edge, with no bubble.

## Configuration
- PREFIX_SUB_ZERO_FLAG_EN defined:
  - Adds the out_zero port.
  - A sticky nonzero bit ORs each difference word into a running flag.
  - On the final word, out_zero = !(sticky | |d).
  - The sticky bit clears on the final word and on reset.
- Macro undefined: port and logic absent; all other behaviour identical.

## Structure
- Shared package prefix_arith_pkg holds:
  - WORD_W = 6.
  - The state enum (FIRST, CHAIN).
  - The gp_t struct (g, p).
  - The prefix dot-operator function, shared with the adder.
- One natural sub-module: prefix_sub6.
  - Combinational, interface (x, y, cin → d, c5, cout).
  - Instanced once; the top owns the handshake, FSM, counter and flags.

## Test plan
- Single word: x=0x05, y=0x03, last=1 → out_d=0x02, borrow=0, ov=0, out_last=1 one cycle later.
- Single-word signed overflow: x=0x20, y=0x01, last=1 → out_d=0x1F, borrow=0, ov=1. Then x=0x00, y=0x01 → out_d=0x3F, borrow=1, ov=0.
- Borrow chaining, 2 words: (x,y)=(0x00,0x01) then (0x01,0x00, last) → out_d=0x3F then 0x00, borrow=0, zero=0 (X=64, Y=1, D=63).
- Forced last, WORDS=4: four words of 0x3F−0x3F with in_last=0 → four results of 0x00, out_last on the 4th, zero=1.
  - The next word starts with cin = 1.
- Backpressure: out_ready=0 for 3 cycles mid-transaction → in_ready=0, out_d stable. Resume yields the correct chained result with no dropped or duplicated word.
- Reset asserted after word 1 of a 3-word transaction → outputs zeroed immediately. The following word 0x04−0x01 (last) gives 0x03, confirming cin = 1.
